id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the RV32I core. Captures the ctrl decoder outputs and decoded operands each cycle.

---
 rtl/id_ex_stage_pkg.sv | 45 ++++
 rtl/id_ex_stage_hazard_detect.sv | 34 +++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared control encodings for the ID/EX pipeline register: enable levels,
// ALU-op and jump codes, the packed control bundle and its NOP value.
package id_ex_stage_pkg;

  localparam logic FUN_ENABLE  = 1'b1;
  localparam logic FUN_DISABLE = 1'b0;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] JUMP_DISABLE = 2'b00;
  localparam logic [1:0] JUMP_JAL     = 2'b01;
  localparam logic [1:0] JUMP_JALR    = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       reg_wena;
    logic       mem2reg;
    logic       mem_rena;
    logic       mem_wena;
    logic [1:0] aluop;
    logic       alusrc;
    logic [1:0] jump;
  } ctrl_t;

  // The bubble bundle: nothing writes, nothing jumps, ALU does a harmless add.
  localparam ctrl_t NOP_CTRL = '{
    branch:   FUN_DISABLE,
    reg_wena: FUN_DISABLE,
    mem2reg:  FUN_DISABLE,
    mem_rena: FUN_DISABLE,
    mem_wena: FUN_DISABLE,
    aluop:    ALUOP_ADD,
    alusrc:   FUN_DISABLE,
    jump:     JUMP_DISABLE
  };

  // Controls of a non-instruction slot are forced to the NOP bundle.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : NOP_CTRL;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare: the load sitting in EX writes a register that the
// instruction in ID reads. Both source indices are always compared, even for
// formats that have no rs2, which can only cost a spurious bubble.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_rena,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  logic [REG_AW-1:0] src_idx [2];
  logic [1:0]        src_match;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = (ex_rd == src_idx[gi]);
    end
  endgenerate

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  always_comb begin
    hazard = ex_valid & ex_mem_rena & (ex_rd != '0) & id_valid & (|src_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded controls and operands, inserts
// NOP bubbles on flush or load-use hazard, freezes on hold, and counts bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_reg_wena,
  input  logic              id_mem2reg,
  input  logic              id_mem_rena,
  input  logic              id_mem_wena,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic [1:0]        id_jump,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_funct,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_reg_wena,
  output logic              ex_mem2reg,
  output logic              ex_mem_rena,
  output logic              ex_mem_wena,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic [1:0]        ex_jump,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_reg;
  ctrl_t             ctrl_reg;
  ctrl_t             id_ctrl;
  logic [XLEN-1:0]   pc_reg, rs1_data_reg, rs2_data_reg, imm_reg;
  logic [REG_AW-1:0] rs1_reg, rs2_reg, rd_reg;
  logic [3:0]        funct_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              hazard;
  logic              bubble_next;
  logic              capture_next;

  assign id_ctrl = '{
    branch:   id_branch,
    reg_wena: id_reg_wena,
    mem2reg:  id_mem2reg,
    mem_rena: id_mem_rena,
    mem_wena: id_mem_wena,
    aluop:    id_aluop,
    alusrc:   id_alusrc,
    jump:     id_jump
  };

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_valid    (valid_reg),
    .ex_mem_rena (ctrl_reg.mem_rena),
    .ex_rd       (rd_reg),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // Edge priority: flush beats hold beats hazard beats a normal capture.
  // A flush never stalls (ID is being killed); reset forces stall low.
  always_comb begin
    bubble_next  = flush_i | (~hold_i & hazard);
    capture_next = ~flush_i & ~hold_i & ~hazard;
    stall_o      = rst_n & ~flush_i & (hold_i | hazard);
  end

  // Pipeline register; bubbles clear only controls and valid, data is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      ctrl_reg     <= NOP_CTRL;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      funct_reg    <= '0;
      cnt_reg      <= '0;
    end else if (bubble_next) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= NOP_CTRL;
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end else if (capture_next) begin
      valid_reg    <= id_valid;
      ctrl_reg     <= gate_ctrl(id_ctrl, id_valid);
      pc_reg       <= id_pc;
      rs1_data_reg <= id_rs1_data;
      rs2_data_reg <= id_rs2_data;
      imm_reg      <= id_imm;
      rs1_reg      <= id_rs1;
      rs2_reg      <= id_rs2;
      rd_reg       <= id_rd;
      funct_reg    <= id_funct;
    end
  end

  assign ex_valid    = valid_reg;
  assign ex_branch   = ctrl_reg.branch;
  assign ex_reg_wena = ctrl_reg.reg_wena;
  assign ex_mem2reg  = ctrl_reg.mem2reg;
  assign ex_mem_rena = ctrl_reg.mem_rena;
  assign ex_mem_wena = ctrl_reg.mem_wena;
  assign ex_aluop    = ctrl_reg.aluop;
  assign ex_alusrc   = ctrl_reg.alusrc;
  assign ex_jump     = ctrl_reg.jump;
  assign ex_pc       = pc_reg;
  assign ex_rs1_data = rs1_data_reg;
  assign ex_rs2_data = rs2_data_reg;
  assign ex_imm      = imm_reg;
  assign ex_rs1      = rs1_reg;
  assign ex_rs2      = rs2_reg;
  assign ex_rd       = rd_reg;
  assign ex_funct    = funct_reg;
  assign bubble_cnt  = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/hold/wrap scenarios followed
// by random traffic, all checked against a cycle-level reference model.
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_ctrl;   // {branch, reg_wena, mem2reg, mem_rena, mem_wena, aluop[1:0], alusrc, jump[1:0]}
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        flush_i, hold_i;

  logic        ex_valid, ex_branch, ex_reg_wena, ex_mem2reg, ex_mem_rena, ex_mem_wena, ex_alusrc;
  logic [1:0]  ex_aluop, ex_jump;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic        stall_o;
  logic [CNT_W-1:0] bubble_cnt;

  wire [9:0] ex_ctrl = {ex_branch, ex_reg_wena, ex_mem2reg, ex_mem_rena, ex_mem_wena,
                        ex_aluop, ex_alusrc, ex_jump};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_branch(id_ctrl[9]), .id_reg_wena(id_ctrl[8]), .id_mem2reg(id_ctrl[7]),
    .id_mem_rena(id_ctrl[6]), .id_mem_wena(id_ctrl[5]), .id_aluop(id_ctrl[4:3]),
    .id_alusrc(id_ctrl[2]), .id_jump(id_ctrl[1:0]),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_reg_wena(ex_reg_wena),
    .ex_mem2reg(ex_mem2reg), .ex_mem_rena(ex_mem_rena), .ex_mem_wena(ex_mem_wena),
    .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_jump(ex_jump),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  // Reference model: what EX should hold, expressed as plain variables.
  bit          m_valid;
  logic [9:0]  m_ctrl;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_funct;
  int          m_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;

  localparam logic [9:0] LW_CTRL  = 10'b0111000100;
  localparam logic [9:0] ADD_CTRL = 10'b0100010000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  // A load in EX whose nonzero destination is read by a real ID instruction.
  function automatic bit model_load_use();
    return m_valid && m_ctrl[6] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs1) || (m_rd == id_rs2));
  endfunction

  task automatic model_clock();
    bit haz;
    haz = model_load_use();
    if (!rst_n) begin
      m_valid = 0; m_ctrl = '0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_funct = '0; m_cnt = 0;
    end else if (flush_i || (!hold_i && haz)) begin
      m_valid = 0; m_ctrl = '0; m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (!hold_i) begin
      m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 10'd0;
      m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
    end
  endtask

  // One clock: stall checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    bit exp_stall;
    @(negedge clk);
    exp_stall = rst_n && !flush_i && (hold_i || model_load_use());
    chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk);
    model_clock();
    #1;
    step_no++;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_ctrl", {22'd0, ex_ctrl}, {22'd0, m_ctrl});
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rs1_data", ex_rs1_data, m_a);
    chk("ex_rs2_data", ex_rs2_data, m_b);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_idx", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m_rs1, m_rs2, m_rd});
    chk("ex_funct", {28'd0, ex_funct}, {28'd0, m_funct});
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    $display("step %0d rst_n=%0b flush=%0b hold=%0b idv=%0b stall=%0b exv=%0b ex_rd=%0d cnt=%0d",
             step_no, rst_n, flush_i, hold_i, id_valid, stall_o, ex_valid, ex_rd, bubble_cnt);
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_ctrl     = 10'($urandom);
    id_pc       = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1      = 5'($urandom_range(0, 7));
    id_rs2      = 5'($urandom_range(0, 7));
    id_rd       = 5'($urandom_range(0, 7));
    id_funct    = 4'($urandom);
  endtask

  task automatic set_instr(input logic [9:0] ctrl, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd);
    rand_id();
    id_valid = 1'b1; id_ctrl = ctrl; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    rand_id();

    // Reset with random ID contents.
    step(); rand_id(); step();
    chk("rst_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);

    // lw x5 ; add x6,x5,x1 -> one bubble, then the add.
    rst_n = 1'b1;
    set_instr(LW_CTRL, 5'd2, 5'd3, 5'd5); step();
    set_instr(ADD_CTRL, 5'd5, 5'd1, 5'd6); step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    step();
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);

    // lw x0 ; add x6,x0,x1 -> no stall.
    set_instr(LW_CTRL, 5'd2, 5'd3, 5'd0); step();
    set_instr(ADD_CTRL, 5'd0, 5'd1, 5'd6); step();
    chk("x0_add_rd", 32'(ex_rd), 32'd6);
    chk("x0_cnt", 32'(bubble_cnt), 32'd1);

    // Flush coinciding with a hazard counts once.
    set_instr(LW_CTRL, 5'd2, 5'd3, 5'd5); step();
    set_instr(ADD_CTRL, 5'd5, 5'd1, 5'd6); flush_i = 1'b1; step();
    chk("fh_cnt", 32'(bubble_cnt), 32'd2);
    flush_i = 1'b0; step();

    // Hold for 3 cycles during a hazard, then the bubble.
    set_instr(LW_CTRL, 5'd2, 5'd3, 5'd5); step();
    set_instr(ADD_CTRL, 5'd5, 5'd1, 5'd6); hold_i = 1'b1;
    step(); step(); step();
    chk("hold_rd", 32'(ex_rd), 32'd5);
    chk("hold_cnt", 32'(bubble_cnt), 32'd2);
    hold_i = 1'b0; step();
    chk("hold_rel_cnt", 32'(bubble_cnt), 32'd3);
    step();
    chk("hold_add_rd", 32'(ex_rd), 32'd6);

    // 17 flushes from reset wrap a 4-bit counter to 1.
    rst_n = 1'b0; step();
    rst_n = 1'b1; flush_i = 1'b1;
    for (int i = 0; i < 17; i++) begin rand_id(); step(); end
    chk("wrap_cnt", 32'(bubble_cnt), 32'd1);
    flush_i = 1'b0;

    // Random traffic; small register range keeps load-use pairs frequent.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      if ($urandom_range(0, 2) == 0) id_ctrl[6] = 1'b1;
      rst_n   = ($urandom_range(0, 49) != 0);
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i  = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
